// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the sequential binary-to-BCD converter
package bcd_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int BCD_DIGIT_W = 4;
  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int k = 0; k < n; k++) r = r * 32'd10;
    return r;
  endfunction
endpackage

// File: rtl/bcd_add3_digit.sv
// bcd_add3_digit: double-dabble digit correction, adds 3 when the digit is 5 or more
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);
  assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/bcd_conv_seq.sv
// bcd_conv_seq: one-bit-per-clock binary-to-BCD converter with start/done handshake and overflow
module bcd_conv_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W    = 7,
  parameter int DIGITS   = 2,
  parameter int SATURATE = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [BIN_W-1:0]                bin,
  output logic                            busy,
  output logic                            done,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd,
  output logic                            ovf
);
  localparam int SW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_VAL = pow10(DIGITS) - 32'd1;
  state_t           state;
  logic [BIN_W-1:0] shift;
  logic [SW-1:0]    scratch, adj, nxt;
  logic [CW-1:0]    cnt;
  logic             ovf_pend;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_add3_digit u_dig (
      .d(scratch[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .q(adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end
  // the top digit's MSB falls off here; it only carries digits beyond DIGITS
  assign nxt = SW'({adj, shift[BIN_W-1]});
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
      shift    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          shift    <= bin;
          scratch  <= '0;
          cnt      <= CW'(BIN_W);
          ovf_pend <= 32'(bin) > MAX_VAL;
          busy     <= 1'b1;
          state    <= SHIFT;
        end
      end else begin
        shift   <= shift << 1;
        scratch <= nxt;
        cnt     <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          bcd   <= (SATURATE != 0 && ovf_pend) ? {DIGITS{4'h9}} : nxt;
          ovf   <= ovf_pend;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_conv_seq.sv
// tb_bcd_conv_seq: vector table, random and corner-sequence checks against an arithmetic model
module tb_bcd_conv_seq;
  logic        clk = 1'b0;
  logic        rst_n, start_a, start_c;
  logic [6:0]  bin_a;
  logic [16:0] bin_c;
  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b, busy_c, done_c, ovf_c;
  logic [7:0]  bcd_a, bcd_b;
  logic [19:0] bcd_c;
  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  bcd_conv_seq #(.BIN_W(7), .DIGITS(2), .SATURATE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a));
  bcd_conv_seq #(.BIN_W(7), .DIGITS(2), .SATURATE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b));
  bcd_conv_seq #(.BIN_W(17), .DIGITS(5), .SATURATE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .bin(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .ovf(ovf_c));

  typedef struct {
    logic [6:0] bin;
    logic [7:0] bcd_sat;
    logic [7:0] bcd_trunc;
    logic       ovf;
  } vec_t;

  // decimal digits of the value (or all nines when saturating an overflow), packed as BCD
  function automatic logic [63:0] model(input longint v, input int digits, input bit sat,
                                        output bit o);
    longint m = 1, x;
    logic [63:0] r = '0;
    for (int i = 0; i < digits; i++) m *= 10;
    o = v > m - 1;
    x = (sat && o) ? m - 1 : v % m;
    for (int i = 0; i < digits; i++) begin
      r |= 64'(x % 10) << (4 * i);
      x /= 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic wait_done(input bit use_c, input int lim, output int k);
    k = 0;
    while (k < lim) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (use_c ? done_c : done_a) break;
    end
  endtask

  task automatic run_ab(input logic [6:0] v, input logic [7:0] es, input logic [7:0] et,
                        input logic eo);
    int k;
    start_a = 1'b1;
    bin_a = v;
    @(posedge clk);
    #1 start_a = 1'b0;
    bin_a = 7'($urandom);
    @(negedge clk);
    chk("busy_a_after_start", busy_a, 1);
    wait_done(1'b0, 20, k);
    chk("latency_a", k, 7);
    chk("bcd_sat", bcd_a, es);
    chk("ovf_sat", ovf_a, eo);
    chk("bcd_trunc", bcd_b, et);
    chk("ovf_trunc", ovf_b, eo);
    chk("busy_a_at_done", busy_a, 0);
    chk("done_b_aligned", done_b, 1);
    @(negedge clk);
    chk("done_a_one_cycle", done_a, 0);
    chk("bcd_a_hold", bcd_a, es);
  endtask

  task automatic run_c(input logic [16:0] v);
    int k;
    bit o;
    logic [63:0] e;
    e = model(longint'(v), 5, 1'b1, o);
    start_c = 1'b1;
    bin_c = v;
    @(posedge clk);
    #1 start_c = 1'b0;
    bin_c = 17'($urandom);
    @(negedge clk);
    chk("busy_c_after_start", busy_c, 1);
    wait_done(1'b1, 40, k);
    chk("latency_c", k, 17);
    chk("bcd_c", bcd_c, e[19:0]);
    chk("ovf_c", ovf_c, o);
  endtask

  initial begin
    vec_t vt[8];
    logic [6:0] hist[24];
    bit o, bad;
    logic [63:0] es, et;
    logic [6:0] v;
    vt[0] = '{7'd57,  8'h57, 8'h57, 1'b0};
    vt[1] = '{7'd99,  8'h99, 8'h99, 1'b0};
    vt[2] = '{7'd0,   8'h00, 8'h00, 1'b0};
    vt[3] = '{7'd127, 8'h99, 8'h27, 1'b1};
    vt[4] = '{7'd100, 8'h99, 8'h00, 1'b1};
    vt[5] = '{7'd1,   8'h01, 8'h01, 1'b0};
    vt[6] = '{7'd10,  8'h10, 8'h10, 1'b0};
    vt[7] = '{7'd109, 8'h99, 8'h09, 1'b1};
    rst_n = 1'b0;
    start_a = 1'b0;
    start_c = 1'b0;
    bin_a = '0;
    bin_c = '0;
    #12;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_bcd", bcd_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_bcd_c", bcd_c, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) run_ab(vt[i].bin, vt[i].bcd_sat, vt[i].bcd_trunc, vt[i].ovf);
    for (int i = 0; i < 30; i++) begin
      v = 7'($urandom_range(0, 127));
      es = model(longint'(v), 2, 1'b1, o);
      et = model(longint'(v), 2, 1'b0, o);
      run_ab(v, es[7:0], et[7:0], o);
    end
    run_c(17'd86399);
    run_c(17'd99999);
    run_c(17'd100000);
    run_c(17'd131071);
    run_c(17'd0);
    for (int i = 0; i < 6; i++) run_c(17'($urandom_range(0, 131071)));
    // start held high: accepted at cycle 0 and in each done cycle's following edge
    for (int c = 0; c < 24; c++) begin
      bin_a = 7'($urandom);
      hist[c] = bin_a;
      start_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("b2b_done", done_a, (c % 8) == 7);
      if (c % 8 == 7) begin
        es = model(longint'(hist[c-7]), 2, 1'b1, o);
        et = model(longint'(hist[c-7]), 2, 1'b0, o);
        chk("b2b_bcd_sat", bcd_a, es[7:0]);
        chk("b2b_bcd_trunc", bcd_b, et[7:0]);
        chk("b2b_ovf", ovf_a, o);
      end
    end
    start_a = 1'b0;
    @(negedge clk);
    run_ab(7'd88, 8'h88, 8'h88, 1'b0);
    start_a = 1'b1;
    bin_a = 7'd120;
    @(posedge clk);
    #1 start_a = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_bcd", bcd_a, 0);
    chk("abort_ovf", ovf_a, 0);
    chk("abort_done", done_a, 0);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bad |= done_a | busy_a;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bad |= done_a | done_b;
    end
    chk("abort_no_done", bad, 0);
    run_ab(7'd42, 8'h42, 8'h42, 1'b0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
